// File: rtl/counter_controller.sv
// rtl/counter_controller.sv - run/stop/clear/direction control unit for the 0-9999 counter
//
// Converts single-cycle command pulses into steady control levels for the
// counter datapath. Each command input is edge-detected, so a held input
// acts once. Build option COUNTER_CTRL_SYNC_EN adds a 2-flop synchronizer
// in front of each edge detector (latency 3 cycles instead of 1).
//
// Ports:
//   clk       system clock, rising edge
//   rst       synchronous active-high reset
//   enable    run/stop command, each rising edge toggles RUN/STOP
//   clear     clear command, each rising edge requests a counter clear
//   mode      direction command, each rising edge toggles direction
//   o_enable  high while in RUN (counter run gate)
//   o_clear   one-cycle clear strobe to the counter
//   o_mode    count direction, 0 = up, 1 = down

module counter_controller (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic clear,
    input  logic mode,
    output logic o_enable,
    output logic o_clear,
    output logic o_mode
);

    typedef enum logic [1:0] {
        ST_STOP  = 2'b00,
        ST_RUN   = 2'b01,
        ST_CLEAR = 2'b10
    } state_t;

    state_t state;
    state_t state_next;

    logic enable_s;
    logic clear_s;
    logic mode_s;

`ifdef COUNTER_CTRL_SYNC_EN
    logic [1:0] enable_sync;
    logic [1:0] clear_sync;
    logic [1:0] mode_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            enable_sync <= 2'b00;
            clear_sync  <= 2'b00;
            mode_sync   <= 2'b00;
        end else begin
            enable_sync <= {enable_sync[0], enable};
            clear_sync  <= {clear_sync[0], clear};
            mode_sync   <= {mode_sync[0], mode};
        end
    end

    assign enable_s = enable_sync[1];
    assign clear_s  = clear_sync[1];
    assign mode_s   = mode_sync[1];
`else
    assign enable_s = enable;
    assign clear_s  = clear;
    assign mode_s   = mode;
`endif

    // Delay registers reset to 0, so an input already high when reset
    // releases is seen as one fresh edge on the first active cycle.
    logic enable_d;
    logic clear_d;
    logic mode_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            enable_d <= 1'b0;
            clear_d  <= 1'b0;
            mode_d   <= 1'b0;
        end else begin
            enable_d <= enable_s;
            clear_d  <= clear_s;
            mode_d   <= mode_s;
        end
    end

    logic enable_edge;
    logic clear_edge;
    logic mode_edge;

    assign enable_edge = enable_s & ~enable_d;
    assign clear_edge  = clear_s  & ~clear_d;
    assign mode_edge   = mode_s   & ~mode_d;

    // Direction flag is independent of the FSM: it toggles in every state,
    // including CLEAR, and a clear does not touch it.
    logic mode_flag;

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_flag <= 1'b0;
        end else if (mode_edge) begin
            mode_flag <= ~mode_flag;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_STOP;
        end else begin
            state <= state_next;
        end
    end

    // Clear wins over enable; enable edges seen while in CLEAR are dropped.
    always_comb begin
        state_next = ST_STOP;
        case (state)
            ST_STOP: begin
                if (clear_edge) begin
                    state_next = ST_CLEAR;
                end else if (enable_edge) begin
                    state_next = ST_RUN;
                end else begin
                    state_next = ST_STOP;
                end
            end
            ST_RUN: begin
                if (clear_edge) begin
                    state_next = ST_CLEAR;
                end else if (enable_edge) begin
                    state_next = ST_STOP;
                end else begin
                    state_next = ST_RUN;
                end
            end
            ST_CLEAR: state_next = ST_STOP;
            default:  state_next = ST_STOP;
        endcase
    end

    // Moore decode from registered state only.
    assign o_enable = (state == ST_RUN);
    assign o_clear  = (state == ST_CLEAR);
    assign o_mode   = mode_flag;

endmodule

// File: tb/tb_counter_controller.sv
// tb/tb_counter_controller.sv - scoreboard bench for counter_controller (default build)

module tb_counter_controller;

    logic clk;
    logic rst;
    logic enable;
    logic clear;
    logic mode;
    logic o_enable;
    logic o_clear;
    logic o_mode;

    counter_controller dut (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .clear    (clear),
        .mode     (mode),
        .o_enable (o_enable),
        .o_clear  (o_clear),
        .o_mode   (o_mode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] exp;
        int         vid;
    } sb_entry_t;

    sb_entry_t sb[$];
    int checks = 0;
    int errors = 0;
    int vid_cnt = 0;

    // Apply one input vector for n cycles; after each clock the expected
    // {o_enable, o_clear, o_mode} is pushed for the monitor to check.
    task automatic vec(input logic r, input logic en, input logic cl, input logic md,
                       input int n, input logic [2:0] exp);
        sb_entry_t e;
        for (int i = 0; i < n; i++) begin
            rst    = r;
            enable = en;
            clear  = cl;
            mode   = md;
            @(posedge clk);
            #1;
            e.exp = exp;
            e.vid = vid_cnt;
            sb.push_back(e);
        end
        vid_cnt++;
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            sb_entry_t e;
            e = sb.pop_front();
            checks++;
            if ({o_enable, o_clear, o_mode} !== e.exp) begin
                errors++;
                $display("FAIL vec%0d outputs en/clr/mode actual %b required %b",
                         e.vid, {o_enable, o_clear, o_mode}, e.exp);
            end
        end
    end

    initial begin
        rst = 1'b1; enable = 1'b0; clear = 1'b0; mode = 1'b0;
        //  rst en  cl  md   n    exp{en,clr,mode}
        vec(1, 0, 0, 0,   2, 3'b000);   // reset
        vec(0, 0, 0, 0, 100, 3'b000);   // idle after reset
        vec(0, 1, 0, 0,   1, 3'b100);   // enable pulse -> RUN
        vec(0, 0, 0, 0,  99, 3'b100);
        vec(0, 1, 0, 0,   1, 3'b000);   // second pulse -> STOP
        vec(0, 0, 0, 0,   5, 3'b000);
        vec(0, 1, 0, 0,   1, 3'b100);   // enable held 50 cycles: one toggle
        vec(0, 1, 0, 0,  49, 3'b100);
        vec(0, 0, 0, 0,   5, 3'b100);
        vec(0, 0, 1, 0,   1, 3'b010);   // clear from RUN
        vec(0, 0, 0, 0,   4, 3'b000);
        vec(0, 0, 0, 1,   1, 3'b001);   // mode in STOP
        vec(0, 0, 0, 0,   2, 3'b001);
        vec(0, 0, 0, 1,   1, 3'b000);
        vec(0, 0, 0, 0,   1, 3'b000);
        vec(0, 1, 0, 0,   1, 3'b100);   // RUN
        vec(0, 0, 0, 1,   1, 3'b101);   // mode in RUN
        vec(0, 0, 0, 0,   1, 3'b101);
        vec(0, 0, 0, 1,   1, 3'b100);
        vec(0, 0, 0, 0,   2, 3'b100);
        vec(0, 0, 0, 1,   1, 3'b101);   // mode=1 then clear keeps mode
        vec(0, 0, 0, 0,   1, 3'b101);
        vec(0, 0, 1, 0,   1, 3'b011);
        vec(0, 0, 0, 0,   3, 3'b001);
        vec(0, 0, 0, 1,   1, 3'b000);
        vec(0, 0, 0, 0,   1, 3'b000);
        vec(0, 1, 1, 1,   1, 3'b011);   // simultaneous from STOP
        vec(0, 0, 0, 0,   3, 3'b001);
        vec(0, 0, 0, 1,   1, 3'b000);
        vec(0, 0, 1, 0,   1, 3'b010);   // enable arriving in CLEAR is dropped
        vec(0, 1, 0, 0,   1, 3'b000);
        vec(0, 0, 0, 0,   3, 3'b000);
        vec(0, 0, 1, 0,   1, 3'b010);   // mode toggles while in CLEAR
        vec(0, 0, 0, 1,   1, 3'b001);
        vec(0, 0, 0, 0,   2, 3'b001);
        vec(0, 1, 0, 0,   1, 3'b101);   // RUN with mode 1
        vec(0, 0, 0, 0,   2, 3'b101);
        vec(1, 0, 0, 0,   1, 3'b000);   // reset mid-RUN
        vec(0, 0, 0, 0,   2, 3'b000);
        vec(1, 1, 0, 0,   2, 3'b000);   // enable held across reset release
        vec(0, 1, 0, 0,   1, 3'b100);
        vec(0, 1, 0, 0,   5, 3'b100);
        vec(0, 0, 0, 0,   3, 3'b100);
        vec(0, 1, 0, 0,   1, 3'b000);   // back-to-back toggles
        vec(0, 0, 0, 0,   1, 3'b000);
        vec(0, 1, 0, 0,   1, 3'b100);
        vec(0, 0, 0, 0,   2, 3'b100);

        repeat (3) @(posedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain actual %0d entries left required 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
